role_mem_rd_arbiter: RTL and testbench
======================================

Name: role_mem_rd_arbiter

Overview:
- Round-robin arbiter that shares the role's single AXI4 read path to the shell DDR4 memory controller (AR/R channels) between NUM_REQ read requesters inside the role.
- Sits between role accelerator engines and the role_to_mem AXI4 master.
- Allows one outstanding burst at a time; the grant is held from AR issue through the R beat carrying rlast.
- Checks beat count against arlen and flags mismatches in a sticky error bit.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ADDR_W, 40, AXI address width.
- DATA_W, 64, AXI read data width.

Ports:
- role_clk  input  1  clock
- role_resetn  input  1  asynchronous active-low reset
- s_araddr  input  NUM_REQ*ADDR_W  per-requester AR address; slice i belongs to requester i
- s_arlen  input  NUM_REQ*8  per-requester burst length minus 1
- s_arsize  input  NUM_REQ*3  per-requester beat size
- s_arburst  input  NUM_REQ*2  per-requester burst type
- s_arvalid  input  NUM_REQ  per-requester AR valid
- s_arready  output  NUM_REQ  per-requester AR ready
- s_rdata  output  DATA_W  R data, broadcast to all requesters
- s_rresp  output  2  R response, broadcast
- s_rlast  output  1  R last, broadcast
- s_rvalid  output  NUM_REQ  per-requester R valid
- s_rready  input  NUM_REQ  per-requester R ready
- m_araddr  output  ADDR_W  to memory AR
- m_arlen  output  8  to memory AR
- m_arsize  output  3  to memory AR
- m_arburst  output  2  to memory AR
- m_arvalid  output  1  to memory AR
- m_arready  input  1  from memory AR
- m_rdata  input  DATA_W  from memory R
- m_rresp  input  2  from memory R
- m_rlast  input  1  from memory R
- m_rvalid  input  1  from memory R
- m_rready  output  1  to memory R
- err_clr  input  1  single-cycle pulse; clears len_err
- len_err  output  1  sticky burst-length mismatch flag
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: single clock role_clk. role_resetn is asynchronous and active-low; assertion immediately forces IDLE.
- Reset values: m_arvalid=0; m_araddr, m_arlen, m_arsize, m_arburst=0; s_arready=0; s_rvalid=0; m_rready=0; len_err=0; busy=0; grant=0; round-robin pointer rr_last=NUM_REQ-1 (so requester 0 wins first).
- State IDLE:
  - If any s_arvalid is high, pick the first requester i scanning from rr_last+1 upward, wrapping modulo NUM_REQ.
  - Register grant=i; latch its araddr/arlen/arsize/arburst into the m_ar* registers and arlen into len_q.
  - Set m_arvalid=1 and go to ADDR. m_arvalid rises one cycle after s_arvalid is sampled.
- State ADDR:
  - m_arvalid stays high; m_ar* stay stable.
  - s_arready[grant] = m_arready, driven combinationally; all other s_arready bits are 0.
  - On m_arready: m_arvalid<=0, beat counter cnt<=0, go to DATA.
  - The requester's arvalid may stay high during ADDR; the arbiter does not re-sample it.
- State DATA:
  - s_rvalid[grant] = m_rvalid and m_rready = s_rready[grant], both combinational; s_rdata/s_rresp/s_rlast are wired straight from m_r*.
  - Non-granted s_rvalid bits are 0.
  - Each handshake (m_rvalid&m_rready) increments cnt, an 8-bit counter.
  - On a handshake with m_rlast=1: rr_last<=grant, go to IDLE. A new arbitration can start the following cycle, so AR issue lags the last R beat by at least one idle cycle.
- Length check, evaluated on each handshake in DATA; any mismatch sets len_err=1:
  - m_rlast=1 while cnt!=len_q (short burst).
  - m_rlast=0 while cnt==len_q (long burst). cnt saturates at 255. The FSM keeps routing until rlast arrives.
- len_err is sticky. err_clr clears it; if a set and err_clr occur in the same cycle, set wins.
- Simultaneous requests: exactly one grant; the loser keeps its arvalid asserted and wins next. Two requesters alternate strictly under continuous demand.
- A requester dropping arvalid in IDLE before being sampled is legal: no grant, no AR.
- rresp is passed through unchanged and does not affect the FSM.
- busy = (state!=IDLE).

Test Plan:
- Single request: s0 araddr=0x1000, arlen=3; m_arready high → m_arvalid high 1 cycle after s_arvalid; 4 beats routed to s_rvalid[0] only; s_rvalid[1]=0 throughout; len_err=0; back to IDLE.
- Contention: s0 and s1 both assert after reset with arlen=0 → grant order s0, s1, s0, s1 over four bursts; m_araddr matches the granted requester each time.
- Backpressure: m_arready low for 5 cycles in ADDR → m_arvalid and m_araddr stable for 6 cycles; s_arready[g] pulses only in the acceptance cycle. With arlen=7 and s_rready[g] toggling 1/0, m_rready mirrors it; exactly 8 beats delivered.
- Length error: arlen=3, memory asserts rlast on beat 2 → len_err=1, FSM in IDLE next cycle. err_clr pulse → len_err=0. Second case: arlen=1 with rlast on beat 3 → len_err=1; all 3 beats delivered.
- Reset mid-burst: deassert role_resetn in DATA after 2 of 4 beats → same-cycle m_rready=0, s_rvalid=0, busy=0. After release, a pending s1 request is granted (pointer back to reset value, so s0 wins if both pending).

Source files
------------

// File: rtl/role_mem_rd_arbiter.sv
// role_mem_rd_arbiter
// ---------------------------------------------------------------------------
// Round-robin arbiter that shares the role's single AXI4 read path (AR/R) to
// the shell DDR4 controller between NUM_REQ requesters. Only one burst is in
// flight at a time: the grant is held from AR issue until the R beat that
// carries rlast. Beats are counted against the granted arlen and any mismatch
// sets a sticky len_err flag.
//
// Ports
//   role_clk, role_resetn       clock, asynchronous active-low reset
//   s_ar*  (per requester)      packed AR channels, slice i = requester i
//   s_arready                   AR ready, only the granted bit can be high
//   s_rdata/s_rresp/s_rlast     R payload broadcast to every requester
//   s_rvalid / s_rready         per-requester R handshake
//   m_ar* / m_r*                AXI4 read master towards memory
//   err_clr                     pulse clearing len_err
//   len_err                     sticky burst-length mismatch flag
//   busy                        high whenever a burst is being arbitrated
// ---------------------------------------------------------------------------
module role_mem_rd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 40,
  parameter int DATA_W  = 64
) (
  input  logic                      role_clk,
  input  logic                      role_resetn,
  input  logic [NUM_REQ*ADDR_W-1:0] s_araddr,
  input  logic [NUM_REQ*8-1:0]      s_arlen,
  input  logic [NUM_REQ*3-1:0]      s_arsize,
  input  logic [NUM_REQ*2-1:0]      s_arburst,
  input  logic [NUM_REQ-1:0]        s_arvalid,
  output logic [NUM_REQ-1:0]        s_arready,
  output logic [DATA_W-1:0]         s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast,
  output logic [NUM_REQ-1:0]        s_rvalid,
  input  logic [NUM_REQ-1:0]        s_rready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic                      err_clr,
  output logic                      len_err,
  output logic                      busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rrLast_q;
  logic [7:0]      cnt_q;
  logic [7:0]      len_q;
  logic            lenErr_q;
  logic [ADDR_W-1:0] mAraddr_q;
  logic [7:0]      mArlen_q;
  logic [2:0]      mArsize_q;
  logic [1:0]      mArburst_q;
  logic            mArvalid_q;

  logic            pickValid;
  logic [GW-1:0]   pickIdx;
  int              scanIdx;
  logic [ADDR_W-1:0] selAddr;
  logic [7:0]      selLen;
  logic [2:0]      selSize;
  logic [1:0]      selBurst;
  logic            rHandshake;
  logic            setErr;

  // Round-robin pick: scan from rrLast+1 upward with wrap. The loop runs from
  // the farthest candidate down to the nearest so the nearest requesting index
  // is the one left standing.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    scanIdx   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scanIdx = (int'(rrLast_q) + k) % NUM_REQ;
      if (s_arvalid[scanIdx]) begin
        pickValid = 1'b1;
        pickIdx   = GW'(scanIdx);
      end
    end
  end

  // AR fields of the requester that is about to be granted.
  always_comb begin
    selAddr  = s_araddr[int'(pickIdx)*ADDR_W +: ADDR_W];
    selLen   = s_arlen[int'(pickIdx)*8 +: 8];
    selSize  = s_arsize[int'(pickIdx)*3 +: 3];
    selBurst = s_arburst[int'(pickIdx)*2 +: 2];
  end

  // Handshake routing. These paths are combinational so the requester and the
  // memory see each other's ready/valid in the same cycle; since they decode
  // the state register, an asynchronous reset drops them immediately.
  always_comb begin
    s_arready = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    if (state_q == ADDR) begin
      s_arready[grant_q] = m_arready;
    end
    if (state_q == DATA) begin
      s_rvalid[grant_q] = m_rvalid;
      m_rready          = s_rready[grant_q];
    end
  end

  // A beat that arrives with rlast at the wrong count is a short burst; a beat
  // that reaches the expected count without rlast is a long burst.
  always_comb begin
    rHandshake = (state_q == DATA) && m_rvalid && m_rready;
    setErr     = rHandshake && ((m_rlast && (cnt_q != len_q)) ||
                                (!m_rlast && (cnt_q == len_q)));
  end

  // Main FSM: arbitration in IDLE, AR issue in ADDR, beat routing in DATA.
  // The pointer resets to the last index so requester 0 wins first.
  always_ff @(posedge role_clk or negedge role_resetn) begin
    if (!role_resetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rrLast_q   <= GW'(NUM_REQ - 1);
      cnt_q      <= '0;
      len_q      <= '0;
      mAraddr_q  <= '0;
      mArlen_q   <= '0;
      mArsize_q  <= '0;
      mArburst_q <= '0;
      mArvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            grant_q    <= pickIdx;
            mAraddr_q  <= selAddr;
            mArlen_q   <= selLen;
            mArsize_q  <= selSize;
            mArburst_q <= selBurst;
            len_q      <= selLen;
            mArvalid_q <= 1'b1;
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            mArvalid_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (rHandshake) begin
            if (cnt_q != 8'hFF) begin
              cnt_q <= cnt_q + 8'd1;
            end
            if (m_rlast) begin
              rrLast_q <= grant_q;
              state_q  <= IDLE;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          mArvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky length error; a new mismatch outranks a clear in the same cycle.
  always_ff @(posedge role_clk or negedge role_resetn) begin
    if (!role_resetn) begin
      lenErr_q <= 1'b0;
    end else if (setErr) begin
      lenErr_q <= 1'b1;
    end else if (err_clr) begin
      lenErr_q <= 1'b0;
    end
  end

  assign m_araddr  = mAraddr_q;
  assign m_arlen   = mArlen_q;
  assign m_arsize  = mArsize_q;
  assign m_arburst = mArburst_q;
  assign m_arvalid = mArvalid_q;
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;
  assign len_err   = lenErr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_role_mem_rd_arbiter.sv
// Directed testbench for role_mem_rd_arbiter with two requesters. The bench
// plays both the requesters and the memory side; every expected value below
// is worked out by hand from the intended behaviour.
module tb_role_mem_rd_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 40;
  localparam int DATA_W  = 64;

  logic                      clk;
  logic                      rstN;
  logic [NUM_REQ*ADDR_W-1:0] sAraddr;
  logic [NUM_REQ*8-1:0]      sArlen;
  logic [NUM_REQ*3-1:0]      sArsize;
  logic [NUM_REQ*2-1:0]      sArburst;
  logic [NUM_REQ-1:0]        sArvalid;
  logic [NUM_REQ-1:0]        sArready;
  logic [DATA_W-1:0]         sRdata;
  logic [1:0]                sRresp;
  logic                      sRlast;
  logic [NUM_REQ-1:0]        sRvalid;
  logic [NUM_REQ-1:0]        sRready;
  logic [ADDR_W-1:0]         mAraddr;
  logic [7:0]                mArlen;
  logic [2:0]                mArsize;
  logic [1:0]                mArburst;
  logic                      mArvalid;
  logic                      mArready;
  logic [DATA_W-1:0]         mRdata;
  logic [1:0]                mRresp;
  logic                      mRlast;
  logic                      mRvalid;
  logic                      mRready;
  logic                      errClr;
  logic                      lenErr;
  logic                      busy;

  int total;
  int bad;

  role_mem_rd_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .role_clk   (clk),
    .role_resetn(rstN),
    .s_araddr   (sAraddr),
    .s_arlen    (sArlen),
    .s_arsize   (sArsize),
    .s_arburst  (sArburst),
    .s_arvalid  (sArvalid),
    .s_arready  (sArready),
    .s_rdata    (sRdata),
    .s_rresp    (sRresp),
    .s_rlast    (sRlast),
    .s_rvalid   (sRvalid),
    .s_rready   (sRready),
    .m_araddr   (mAraddr),
    .m_arlen    (mArlen),
    .m_arsize   (mArsize),
    .m_arburst  (mArburst),
    .m_arvalid  (mArvalid),
    .m_arready  (mArready),
    .m_rdata    (mRdata),
    .m_rresp    (mRresp),
    .m_rlast    (mRlast),
    .m_rvalid   (mRvalid),
    .m_rready   (mRready),
    .err_clr    (errClr),
    .len_err    (lenErr),
    .busy       (busy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  // Advance to just after the next rising edge, where inputs are driven and
  // registered outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Put every input into a quiet state.
  task automatic idle_inputs();
    sAraddr  = '0;
    sArlen   = '0;
    sArsize  = '0;
    sArburst = '0;
    sArvalid = '0;
    sRready  = '0;
    mArready = 1'b1;
    mRdata   = '0;
    mRresp   = '0;
    mRlast   = 1'b0;
    mRvalid  = 1'b0;
    errClr   = 1'b0;
  endtask

  // Pulse reset for a couple of cycles and release it between edges.
  task automatic do_reset();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
  endtask

  // Reset values, with R-side inputs active so gating is actually exercised.
  task automatic test_reset();
    idle_inputs();
    rstN    = 1'b0;
    mRvalid = 1'b1;
    sRready = 2'b11;
    sArvalid = 2'b11;
    tick();
    tick();
    total++;
    if (mArvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_arvalid got=%b want=0", mArvalid);
    end
    total++;
    if (mAraddr !== '0 || mArlen !== 8'd0 || mArsize !== 3'd0 || mArburst !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_ar_fields got=%h/%h/%h/%h want=0", mAraddr, mArlen, mArsize, mArburst);
    end
    total++;
    if (sArready !== 2'b00 || sRvalid !== 2'b00 || mRready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_handshake got=%b/%b/%b want=00/00/0", sArready, sRvalid, mRready);
    end
    total++;
    if (lenErr !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%b/%b want=0/0", lenErr, busy);
    end
    idle_inputs();
    rstN = 1'b1;
    tick();
  endtask

  // One 4-beat burst from requester 0 with memory always ready.
  task automatic test_single();
    int delivered;
    do_reset();
    sAraddr[0 +: ADDR_W] = 40'h1000;
    sArlen[0 +: 8]       = 8'd3;
    sArsize[0 +: 3]      = 3'd3;
    sArburst[0 +: 2]     = 2'd1;
    sArvalid             = 2'b01;
    #1;
    total++;
    if (mArvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_arvalid_early got=%b want=0", mArvalid);
    end
    tick();
    total++;
    if (mArvalid !== 1'b1 || mAraddr !== 40'h1000 || mArlen !== 8'd3 || mArsize !== 3'd3 || mArburst !== 2'd1) begin
      bad++;
      $display("[TB] FAIL single_ar got=%b/%h/%h/%h/%h want=1/1000/03/3/1", mArvalid, mAraddr, mArlen, mArsize, mArburst);
    end
    total++;
    if (sArready !== 2'b01) begin
      bad++;
      $display("[TB] FAIL single_arready got=%b want=01", sArready);
    end
    sArvalid = 2'b00;
    tick();
    total++;
    if (mArvalid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_data_entry got=%b/%b want=0/1", mArvalid, busy);
    end
    delivered = 0;
    sRready   = 2'b11;
    for (int b = 0; b < 4; b++) begin
      mRvalid = 1'b1;
      mRdata  = 64'hA0 + 64'(b);
      mRlast  = (b == 3);
      #1;
      total++;
      if (sRvalid !== 2'b01 || mRready !== 1'b1 || sRdata !== 64'hA0 + 64'(b) || sRlast !== (b == 3)) begin
        bad++;
        $display("[TB] FAIL single_beat%0d got=%b/%b/%h/%b want=01/1/%h/%b", b, sRvalid, mRready, sRdata, sRlast, 64'hA0 + 64'(b), (b == 3));
      end
      if (sRvalid[0] && mRready) delivered++;
      tick();
    end
    mRvalid = 1'b0;
    mRlast  = 1'b0;
    total++;
    if (delivered != 4 || busy !== 1'b0 || lenErr !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_end got=%0d/%b/%b want=4/0/0", delivered, busy, lenErr);
    end
  endtask

  // Both requesters demand continuously; grants must alternate 0,1,0,1.
  task automatic test_contention();
    int expG;
    logic [ADDR_W-1:0] expAddr;
    do_reset();
    sAraddr[0 +: ADDR_W]      = 40'h2000;
    sAraddr[ADDR_W +: ADDR_W] = 40'h3000;
    sArlen   = '0;
    sArvalid = 2'b11;
    sRready  = 2'b11;
    mArready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      expG    = n % 2;
      expAddr = (expG == 0) ? 40'h2000 : 40'h3000;
      tick();
      total++;
      if (mArvalid !== 1'b1 || mAraddr !== expAddr || sArready !== 2'(1 << expG)) begin
        bad++;
        $display("[TB] FAIL contention_ar%0d got=%b/%h/%b want=1/%h/%b", n, mArvalid, mAraddr, sArready, expAddr, 2'(1 << expG));
      end
      tick();
      mRvalid = 1'b1;
      mRlast  = 1'b1;
      #1;
      total++;
      if (sRvalid !== 2'(1 << expG)) begin
        bad++;
        $display("[TB] FAIL contention_r%0d got=%b want=%b", n, sRvalid, 2'(1 << expG));
      end
      tick();
      mRvalid = 1'b0;
      mRlast  = 1'b0;
    end
    sArvalid = 2'b00;
    tick();
  endtask

  // A request withdrawn between edges in IDLE must not be granted.
  task automatic test_drop();
    sArvalid = 2'b01;
    #2;
    sArvalid = 2'b00;
    tick();
    total++;
    if (busy !== 1'b0 || mArvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drop_no_grant got=%b/%b want=0/0", busy, mArvalid);
    end
  endtask

  // AR stall for five cycles, then an 8-beat burst with toggling rready.
  task automatic test_backpressure();
    int beats;
    sAraddr[0 +: ADDR_W] = 40'h4000;
    sArlen[0 +: 8]       = 8'd7;
    sArvalid             = 2'b01;
    mArready             = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      total++;
      if (mArvalid !== 1'b1 || mAraddr !== 40'h4000 || sArready !== 2'b00) begin
        bad++;
        $display("[TB] FAIL bp_stall%0d got=%b/%h/%b want=1/4000/00", c, mArvalid, mAraddr, sArready);
      end
      tick();
    end
    mArready = 1'b1;
    #1;
    total++;
    if (mArvalid !== 1'b1 || mAraddr !== 40'h4000 || sArready !== 2'b01) begin
      bad++;
      $display("[TB] FAIL bp_accept got=%b/%h/%b want=1/4000/01", mArvalid, mAraddr, sArready);
    end
    sArvalid = 2'b00;
    tick();
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      sRready = (c % 2 == 0) ? 2'b01 : 2'b10;
      mRvalid = 1'b1;
      mRlast  = (beats == 7);
      #1;
      total++;
      if (mRready !== sRready[0]) begin
        bad++;
        $display("[TB] FAIL bp_rready_c%0d got=%b want=%b", c, mRready, sRready[0]);
      end
      if (mRready === 1'b1) beats++;
      tick();
    end
    mRvalid = 1'b0;
    mRlast  = 1'b0;
    sRready = 2'b11;
    total++;
    if (beats != 8 || busy !== 1'b0 || lenErr !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_end got=%0d/%b/%b want=8/0/0", beats, busy, lenErr);
    end
  endtask

  // Short burst, clear, then a long burst that still routes every beat.
  task automatic test_len_error();
    int delivered;
    sAraddr[ADDR_W +: ADDR_W] = 40'h5000;
    sArlen[8 +: 8]            = 8'd3;
    sArvalid                  = 2'b10;
    sRready                   = 2'b11;
    tick();
    sArvalid = 2'b00;
    tick();
    mRvalid = 1'b1;
    mRlast  = 1'b0;
    tick();
    total++;
    if (lenErr !== 1'b0) begin
      bad++;
      $display("[TB] FAIL len_short_beat0 got=%b want=0", lenErr);
    end
    mRlast = 1'b1;
    tick();
    mRvalid = 1'b0;
    mRlast  = 1'b0;
    total++;
    if (lenErr !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL len_short got=%b/%b want=1/0", lenErr, busy);
    end
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    total++;
    if (lenErr !== 1'b0) begin
      bad++;
      $display("[TB] FAIL len_clear got=%b want=0", lenErr);
    end
    sAraddr[0 +: ADDR_W] = 40'h6000;
    sArlen[0 +: 8]       = 8'd1;
    sArvalid             = 2'b01;
    tick();
    sArvalid = 2'b00;
    tick();
    delivered = 0;
    for (int b = 0; b < 3; b++) begin
      mRvalid = 1'b1;
      mRlast  = (b == 2);
      #1;
      if (sRvalid === 2'b01 && mRready === 1'b1) delivered++;
      tick();
      if (b == 1) begin
        total++;
        if (lenErr !== 1'b1 || busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL len_long_mid got=%b/%b want=1/1", lenErr, busy);
        end
      end
    end
    mRvalid = 1'b0;
    mRlast  = 1'b0;
    total++;
    if (delivered != 3 || lenErr !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL len_long_end got=%0d/%b/%b want=3/1/0", delivered, lenErr, busy);
    end
  endtask

  // Reset in the middle of a burst, then check the pointer restarts at 0.
  task automatic test_reset_mid_burst();
    sAraddr[0 +: ADDR_W]      = 40'h7000;
    sAraddr[ADDR_W +: ADDR_W] = 40'h8000;
    sArlen                    = {8'd3, 8'd3};
    sArvalid                  = 2'b01;
    sRready                   = 2'b11;
    tick();
    sArvalid = 2'b00;
    tick();
    mRvalid = 1'b1;
    mRlast  = 1'b0;
    tick();
    tick();
    #1;
    total++;
    if (mRready !== 1'b1 || sRvalid !== 2'b01 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_mid_pre got=%b/%b/%b want=1/01/1", mRready, sRvalid, busy);
    end
    rstN = 1'b0;
    #1;
    total++;
    if (mRready !== 1'b0 || sRvalid !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_mid_async got=%b/%b/%b want=0/00/0", mRready, sRvalid, busy);
    end
    mRvalid = 1'b0;
    tick();
    rstN     = 1'b1;
    sArvalid = 2'b11;
    tick();
    total++;
    if (mArvalid !== 1'b1 || mAraddr !== 40'h7000) begin
      bad++;
      $display("[TB] FAIL rst_mid_regrant got=%b/%h want=1/7000", mArvalid, mAraddr);
    end
    sArvalid = 2'b00;
  endtask

  // Run every scenario in order and print the summary.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_contention();
    test_drop();
    test_backpressure();
    test_len_error();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
